// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 line encoder.
// Default timing constants assume a 20 MHz clock.
package ws2812_pkg;

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    localparam int PX_W        = 24;
    localparam int T0H_DEF     = 8;
    localparam int T1H_DEF     = 16;
    localparam int T_BIT_DEF   = 25;
    localparam int T_RESET_DEF = 1000;

    // One counter serves both bit timing and the latch gap.
    function automatic int cnt_w(input int t_bit, input int t_reset);
        return $clog2(t_bit > t_reset ? t_bit : t_reset);
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Cycle counter for one WS2812 bit or the latch gap.
// o_led_nxt is the line level for the cycle after the current one.
module ws2812_bit_timer #(
    parameter int T0H     = 8,
    parameter int T1H     = 16,
    parameter int T_BIT   = 25,
    parameter int T_RESET = 1000,
    parameter int CW      = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_bit,
    output logic o_led_nxt,
    output logic o_bit_done,
    output logic o_lat_done
);

    logic [CW-1:0] r_cnt;
    logic [CW:0]   w_cnt_inc;
    logic [CW:0]   w_thr;

    assign w_cnt_inc  = {1'b0, r_cnt} + (CW+1)'(1);
    assign w_thr      = i_bit ? (CW+1)'(T1H) : (CW+1)'(T0H);
    // led is registered, so compare against the count it will be shown with
    assign o_led_nxt  = (w_cnt_inc < w_thr);
    assign o_bit_done = (r_cnt == CW'(T_BIT - 1));
    assign o_lat_done = (r_cnt == CW'(T_RESET - 1));

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_inc[CW-1:0];
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// Streaming WS2812 encoder: per-pixel valid/ready in, pulse-width-coded line out.
// A one-deep hold register lets the next pixel load gap-free when the current one ends.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int T0H     = T0H_DEF,
    parameter int T1H     = T1H_DEF,
    parameter int T_BIT   = T_BIT_DEF,
    parameter int T_RESET = T_RESET_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PX_W-1:0] px_data,
    input  logic            px_last,
    input  logic            px_valid,
    output logic            px_ready,
    output logic            led,
    output logic            busy,
    output logic            underrun
);

    localparam int CW = cnt_w(T_BIT, T_RESET);

    if (!(T0H >= 1 && T0H < T1H && T1H < T_BIT && T_RESET >= 1)) begin : g_bad_params
        $error("ws2812_tx: illegal timing parameters");
    end

    state_t          r_state, w_state_n;
    logic [PX_W-1:0] r_hold_data, r_shift;
    logic            r_hold_last, r_hold_valid, r_last_q;
    logic [4:0]      r_bit;
    logic            r_led, r_underrun;

    logic w_accept, w_load, w_shift, w_clr, w_led_n, w_underrun_n;
    logic w_led_nxt, w_bit_done, w_lat_done;

    assign px_ready = !r_hold_valid;
    assign w_accept = px_valid && !r_hold_valid;
    assign led      = r_led;
    assign underrun = r_underrun;
    assign busy     = (r_state != IDLE) || r_hold_valid;

    ws2812_bit_timer #(
        .T0H     (T0H),
        .T1H     (T1H),
        .T_BIT   (T_BIT),
        .T_RESET (T_RESET),
        .CW      (CW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_clr),
        .i_bit      (r_shift[PX_W-1]),
        .o_led_nxt  (w_led_nxt),
        .o_bit_done (w_bit_done),
        .o_lat_done (w_lat_done)
    );

    always_comb begin
        w_state_n    = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clr        = 1'b0;
        w_led_n      = 1'b0;
        w_underrun_n = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (r_hold_valid) begin
                    w_load    = 1'b1;
                    w_led_n   = 1'b1;
                    w_state_n = SEND;
                end
            end
            SEND: begin
                w_led_n = w_led_nxt;
                if (w_bit_done) begin
                    w_clr = 1'b1;
                    if (r_bit != '0) begin
                        w_shift = 1'b1;
                        w_led_n = 1'b1;
                    end else if (r_last_q) begin
                        w_led_n   = 1'b0;
                        w_state_n = LATCH;
                    end else if (r_hold_valid) begin
                        w_load  = 1'b1;
                        w_led_n = 1'b1;
                    end else begin
                        // pixel ran dry mid-frame; the latch gap ends the frame early
                        w_led_n      = 1'b0;
                        w_underrun_n = 1'b1;
                        w_state_n    = LATCH;
                    end
                end
            end
            LATCH: begin
                if (w_lat_done) begin
                    w_clr     = 1'b1;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_led        <= 1'b0;
            r_underrun   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_hold_last  <= 1'b0;
            r_shift      <= '0;
            r_bit        <= '0;
            r_last_q     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_led      <= w_led_n;
            r_underrun <= w_underrun_n;
            // accept and load are exclusive: accept needs the hold empty, load needs it full
            if (w_accept) begin
                r_hold_data  <= px_data;
                r_hold_last  <= px_last;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
            if (w_load) begin
                r_shift  <= r_hold_data;
                r_last_q <= r_hold_last;
                r_bit    <= 5'(PX_W - 1);
            end else if (w_shift) begin
                r_shift <= {r_shift[PX_W-2:0], 1'b0};
                r_bit   <= r_bit - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: expected bits are queued on accept and popped as the line is decoded.
module tb_ws2812_tx;
    localparam int T0H = 2, T1H = 4, T_BIT = 6, T_RESET = 10;
    localparam int PXC = 24 * T_BIT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] px_data = '0;
    logic        px_last = 1'b0;
    logic        px_valid = 1'b0;
    logic        px_ready, led, busy, underrun;

    always #5 clk = ~clk;

    ws2812_tx #(.T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_RESET(T_RESET)) dut (
        .clk(clk), .reset(reset), .px_data(px_data), .px_last(px_last),
        .px_valid(px_valid), .px_ready(px_ready), .led(led), .busy(busy),
        .underrun(underrun)
    );

    int n_cmp = 0, n_bad = 0;
    bit exp_q[$];
    int cyc = 0, hi = 0, lo = 0;
    bit in_bit = 0, busy_q = 0;
    int bit_end = -10, burst_rise = 0, busy_fall = 0, n_und = 0, und_cyc = 0;

    task automatic chk(string tag, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic finish_bit();
        bit e;
        if (exp_q.size() == 0) chk("extra_bit", 1, 0);
        else begin
            e = exp_q.pop_front();
            chk("bit_hi", hi, e ? T1H : T0H);
        end
        bit_end = cyc;
        in_bit  = 0;
    endtask

    // line decoder, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            in_bit = 0; hi = 0; lo = 0;
        end else if (led) begin
            if (in_bit && lo != 0) begin
                chk("short_bit", hi + lo, T_BIT);
                in_bit = 0;
            end
            if (!in_bit) begin
                if (cyc != bit_end + 1) burst_rise = cyc;
                in_bit = 1; hi = 0; lo = 0;
            end
            hi++;
            if (hi >= T_BIT) begin
                chk("stuck_high", hi, T1H);
                in_bit = 0;
            end
        end else if (in_bit) begin
            lo++;
            if (hi + lo == T_BIT) finish_bit();
        end
        if (underrun) begin n_und++; und_cyc = cyc; end
        if (busy_q && !busy) busy_fall = cyc;
        busy_q = busy;
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_px(input logic [23:0] d, input logic l, output int waited);
        px_data = d; px_last = l; px_valid = 1'b1; waited = 0;
        while (!px_ready && waited < 1000) begin tick(); waited++; end
        if (!px_ready) chk("accept_timeout", 0, 1);
        else begin
            tick(); waited++;
            for (int i = 23; i >= 0; i--) exp_q.push_back(d[i]);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || led) && n < 3000) begin tick(); n++; end
        if (busy) chk("idle_timeout", 1, 0);
        tick(2);
    endtask

    task automatic wait_rise();
        int n = 0;
        while (!led && n < 100) begin tick(); n++; end
        if (!led) chk("rise_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, n, ra;
        reset = 1'b1;
        tick(3);
        chk("rst_led", led, 0);
        chk("rst_ready", px_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        reset = 1'b0;
        tick(2);

        // single last pixel
        send_px(24'h800001, 1'b1, w); px_valid = 1'b0;
        wait_idle();
        chk("t1_bits_left", exp_q.size(), 0);
        chk("t1_busy_fall", busy_fall - burst_rise, PXC + T_RESET);
        chk("t1_underrun", n_und, 0);

        // two pixels back to back, valid held
        send_px(24'hFFFFFF, 1'b0, w);
        send_px(24'h000000, 1'b1, w); px_valid = 1'b0;
        chk("t2_accept_wait", w, 2);
        n = 0;
        while (!px_ready && n < 500) begin tick(); n++; end
        chk("t2_ready_low", n, PXC - 1);
        wait_idle();
        chk("t2_bits_left", exp_q.size(), 0);
        chk("t2_span", bit_end - burst_rise + 1, 2 * PXC);
        chk("t2_busy_fall", busy_fall - burst_rise, 2 * PXC + T_RESET);
        chk("t2_underrun", n_und, 0);

        // non-last pixel with nothing following
        send_px(24'h0F0F0F, 1'b0, w); px_valid = 1'b0;
        wait_idle();
        chk("t3_bits_left", exp_q.size(), 0);
        chk("t3_und_pulses", n_und, 1);
        chk("t3_und_cyc", und_cyc - burst_rise, PXC);
        chk("t3_busy_fall", busy_fall - burst_rise, PXC + T_RESET);

        // reset during the high phase of bit 5
        send_px(24'hFFFFFF, 1'b1, w); px_valid = 1'b0;
        wait_rise();
        tick((23 - 5) * T_BIT + 1);
        chk("t4_pre_led", led, 1);
        reset = 1'b1;
        tick();
        chk("t4_rst_led", led, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_ready", px_ready, 1);
        reset = 1'b0;
        exp_q.delete();
        tick(T_RESET);
        n_und = 0;
        send_px(24'h5A3C96, 1'b1, w); px_valid = 1'b0;
        wait_idle();
        chk("t4_bits_left", exp_q.size(), 0);
        chk("t4_busy_fall", busy_fall - burst_rise, PXC + T_RESET);

        // pixel offered during the latch gap
        send_px(24'hA5A5A5, 1'b1, w); px_valid = 1'b0;
        wait_rise();
        tick(PXC + 3);
        ra = burst_rise;
        chk("t5_in_latch", busy && !led, 1);
        send_px(24'h3C3C3C, 1'b1, w); px_valid = 1'b0;
        chk("t5_accept_wait", w, 1);
        chk("t5_ready_low", px_ready, 0);
        wait_idle();
        chk("t5_bits_left", exp_q.size(), 0);
        chk("t5_gap", burst_rise - ra, PXC + T_RESET + 1);
        chk("t5_underrun", n_und, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
